// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32 constants, the fetch-buffer entry layout and a
//                PC alignment helper used by the instruction-fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Architectural widths
    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // Byte distance between consecutive instruction words
    localparam logic [XLEN-1:0] INSTR_ALIGN = 32'd4;

    // ADDI x0,x0,0 - placed into flushed IF/ID slots by downstream logic
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address down to the enclosing instruction word
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(INSTR_ALIGN - 32'd1);
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous circular FIFO with push, pop, flush, an occupancy
//                count and asynchronous active-high reset that also clears
//                storage, so the head reads as zero straight out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    logic             w_push;
    logic             w_pop;

    // Flush wins over both ports; a pop of an empty FIFO is ignored, and a
    // push into a full FIFO is only taken when the head leaves the same cycle.
    assign w_pop  = pop_i && !flush_i && (count_q != '0);
    assign w_push = push_i && !flush_i && ((count_q != c_FULL) || w_pop);

    // Pointer, count and storage update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_ONE;
                2'b01:   count_q <= count_q - c_CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // When a pop empties the FIFO together with a push, rd_ptr advances onto
    // the slot just written, so the new word is the head on the next cycle.
    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_prefetch
//  Description : Instruction-fetch front end. Owns the fetch PC, issues word
//                requests over a grant / in-order-response memory handshake,
//                buffers returned words with their PCs and hands them to
//                decode with valid/ready. A redirect from EX flushes the
//                buffer and drops every response still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_prefetch
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    output logic [31:0] fetch_pc,
    output logic        resp_err
);

    // Occupancy counters hold 0..DEPTH inclusive
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
    localparam int            c_EW    = $bits(fetch_entry_t);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;   // next address to request
    logic [XLEN-1:0] resp_pc_q,  resp_pc_d;    // PC of next kept response
    logic [CW-1:0]   inflight_q, inflight_d;   // granted, not yet returned
    logic [CW-1:0]   discard_q,  discard_d;    // in-flight words to drop
    logic            resp_err_q, resp_err_d;   // sticky protocol error

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic            w_room;
    logic            w_req;
    logic            w_grant;
    logic            w_resp;
    logic            w_spurious;
    logic            w_push;
    logic            w_pop;
    logic            w_id_valid;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_grant_inc;
    logic [CW-1:0]   w_resp_dec;
    logic [XLEN-1:0] w_target;

    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head_entry;
    logic [c_EW-1:0] w_head_bits;

    // Buffered words plus reserved in-flight slots must stay within DEPTH,
    // which is what makes a FIFO overflow impossible.
    assign w_room   = (w_count + inflight_q) < c_DEPTH;
    assign w_req    = !reset && !redirect_valid && w_room;
    assign w_grant  = w_req && imem_gnt;

    // A response only counts when something is actually outstanding
    assign w_resp     = imem_rvalid && (inflight_q != '0);
    assign w_spurious = imem_rvalid && (inflight_q == '0);

    // Stale words (pre-redirect fetches) and any word arriving alongside a
    // redirect are dropped instead of entering the buffer.
    assign w_push   = w_resp && (discard_q == '0) && !redirect_valid;

    // Decode never sees an instruction in the cycle EX is redirecting
    assign w_id_valid = (w_count != '0) && !redirect_valid;
    assign w_pop      = w_id_valid && id_ready;

    assign w_target    = align_pc(redirect_pc);
    assign w_grant_inc = {{(CW-1){1'b0}}, w_grant};
    assign w_resp_dec  = {{(CW-1){1'b0}}, w_resp};

    assign w_push_entry = '{pc: resp_pc_q, instr: imem_rdata};
    assign w_head_entry = fetch_entry_t'(w_head_bits);

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_EW)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (redirect_valid),
        .head_data_o (w_head_bits),
        .count_o     (w_count)
    );

    // Next-state for PCs, in-flight bookkeeping and the error flag
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        resp_err_d = resp_err_q | w_spurious;
        inflight_d = inflight_q + w_grant_inc - w_resp_dec;

        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the
            // old path; a second redirect simply recomputes the drop count.
            fetch_pc_d = w_target;
            resp_pc_d  = w_target;
            discard_d  = inflight_q - w_resp_dec;
        end else begin
            if (w_grant) begin
                fetch_pc_d = fetch_pc_q + INSTR_ALIGN;
            end
            if (w_push) begin
                resp_pc_d = resp_pc_q + INSTR_ALIGN;
            end
            if (w_resp && (discard_q != '0)) begin
                discard_d = discard_q - {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            resp_err_q <= resp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req  = w_req;
    assign imem_addr = fetch_pc_q;
    assign fetch_pc  = fetch_pc_q;
    assign resp_err  = resp_err_q;
    assign id_valid  = w_id_valid;
    assign id_instr  = w_head_entry.instr;
    assign id_pc     = w_head_entry.pc;

endmodule : ifetch_prefetch
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_prefetch
//  Description : Self-checking bench for ifetch_prefetch. A memory model
//                grants requests and returns words in order after a
//                configurable latency; a scoreboard queues every expected
//                (pc, instr) at grant time and compares on each decode pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [31:0] fetch_pc;
    logic        resp_err;

    ifetch_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready),
        .fetch_pc       (fetch_pc),
        .resp_err       (resp_err)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } pend_t;

    pend_t       pend_q[$];     // words the memory still owes, in order
    logic [31:0] exp_q[$];      // PCs decode should see, oldest first

    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          n_grants = 0;
    int          n_pass = 0;
    int          n_chk = 0;
    bit          gnt_on = 1'b1;
    bit          gnt_rand = 1'b0;
    bit          rv_rand = 1'b0;
    bit          spur_req = 1'b0;
    bit          mon_en = 1'b0;
    bit          watch_first = 1'b0;
    logic [31:0] first_pc = 32'hFFFF_FFFF;
    logic [31:0] m_fetch_pc = RESET_PC;

    // Memory contents: a scrambled function of the word address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        pend_q.delete();
        exp_q.delete();
        m_fetch_pc = RESET_PC;
        epoch++;
    endtask

    // Reset asserted mid-cycle; outputs must return to reset values at once
    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_imem_req",  imem_req,  1'b0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_fetch_pc",  fetch_pc,  RESET_PC);
        check("rst_id_valid",  id_valid,  1'b0);
        check("rst_id_instr",  id_instr,  32'h0);
        check("rst_id_pc",     id_pc,     32'h0);
        check("rst_resp_err",  resp_err,  1'b0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        n_grants = 0;
    endtask

    // Memory model and scoreboard: drive just after the falling edge, sample
    // one time unit before the rising edge.
    initial begin : mem_mon
        int          nonstale;
        int          stale;
        int          mcount;
        logic        exp_req;
        logic        exp_idv;
        logic [31:0] e;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            imem_gnt    = gnt_rand ? ($urandom_range(0, 1) == 1) : gnt_on;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (spur_req) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                spur_req    = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc &&
                         (!rv_rand || $urandom_range(0, 2) != 0)) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pend_q[0].addr);
            end
            #3;
            if (mon_en && !reset) begin
                nonstale = 0;
                foreach (pend_q[i]) begin
                    if (pend_q[i].epoch == epoch) nonstale++;
                end
                stale   = pend_q.size() - nonstale;
                mcount  = exp_q.size() - nonstale;
                exp_req = !redirect_valid && ((exp_q.size() + stale) < DEPTH);
                exp_idv = (mcount != 0) && !redirect_valid;
                check("imem_req",  imem_req,  exp_req);
                check("imem_addr", imem_addr, m_fetch_pc);
                check("fetch_pc",  fetch_pc,  m_fetch_pc);
                check("id_valid",  id_valid,  exp_idv);
                if (exp_idv && id_ready) begin
                    e = exp_q.pop_front();
                    check("id_pc",    id_pc,    e);
                    check("id_instr", id_instr, instr_of(e));
                    if (watch_first) begin
                        first_pc    = id_pc;
                        watch_first = 1'b0;
                    end
                end
                if (imem_rvalid && pend_q.size() > 0) begin
                    void'(pend_q.pop_front());
                end
                if (redirect_valid) begin
                    epoch++;
                    exp_q.delete();
                    m_fetch_pc = redirect_pc & ~32'h3;
                end else if (exp_req && imem_gnt) begin
                    exp_q.push_back(m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
                if (imem_req && imem_gnt) begin
                    pend_q.push_back('{addr: imem_addr, due: cyc + lat, epoch: epoch});
                    n_grants++;
                end
            end
            cyc++;
        end
    end

    initial begin : stim
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #3;
        check("reset_imem_req",  imem_req,  1'b0);
        check("reset_imem_addr", imem_addr, RESET_PC);
        check("reset_id_valid",  id_valid,  1'b0);
        check("reset_id_instr",  id_instr,  32'h0);
        check("reset_id_pc",     id_pc,     32'h0);
        check("reset_resp_err",  resp_err,  1'b0);
        model_clear();
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Streaming: one request per cycle, id_valid two cycles after grant
        #3;
        check("stream_addr0", imem_addr, 32'h0);
        check("stream_req0",  imem_req,  1'b1);
        @(negedge clk);
        #3;
        check("stream_addr1", imem_addr, 32'h4);
        check("stream_idv1",  id_valid,  1'b0);
        @(negedge clk);
        #3;
        check("stream_addr2", imem_addr, 32'h8);
        check("stream_idv2",  id_valid,  1'b1);
        check("stream_pc2",   id_pc,     32'h0);
        check("stream_ins2",  id_instr,  instr_of(32'h0));
        repeat (8) @(negedge clk);

        // Backpressure: decode stalled, fetch stops after DEPTH grants
        pulse_reset();
        id_ready = 1'b0;
        repeat (9) @(negedge clk);
        #3;
        check("full_grants", n_grants,  4);
        check("full_req",    imem_req,  1'b0);
        check("full_addr",   imem_addr, 32'h10);
        check("full_id_pc",  id_pc,     32'h0);
        check("full_idv",    id_valid,  1'b1);
        @(negedge clk);
        id_ready = 1'b1;
        #3;
        check("full_req_still0", imem_req, 1'b0);
        @(negedge clk);
        #3;
        check("resume_req",  imem_req,  1'b1);
        check("resume_addr", imem_addr, 32'h10);
        repeat (6) @(negedge clk);

        // Redirect with several responses in flight (latency 3)
        lat = 3;
        repeat (10) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #3;
        check("redir_idv", id_valid, 1'b0);
        check("redir_req", imem_req, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        watch_first    = 1'b1;
        #3;
        check("redir_addr",     imem_addr, 32'h100);
        check("redir_req_next", imem_req,  1'b1);
        repeat (12) @(negedge clk);
        check("redir_first_pc", first_pc, 32'h100);

        // Back-to-back redirects while stale words are still owed
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        redirect_pc    = 32'h0000_0302;
        @(negedge clk);
        redirect_valid = 1'b0;
        watch_first    = 1'b1;
        repeat (12) @(negedge clk);
        check("redir2_first_pc", first_pc, 32'h300);

        // Redirect coinciding with a response and a pending pop (latency 1)
        lat = 1;
        repeat (6) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        #3;
        check("rv_redir_idv", id_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("rv_redir_empty", id_valid,  1'b0);
        check("rv_redir_addr",  imem_addr, 32'h2000);
        repeat (4) @(negedge clk);

        // Random grant / response / decode backpressure
        gnt_rand = 1'b1;
        rv_rand  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            id_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        gnt_rand = 1'b0;
        gnt_on   = 1'b0;
        rv_rand  = 1'b0;
        id_ready = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        check("drain_idv", id_valid, 1'b0);

        // Spurious response with the buffer full and nothing outstanding
        check("err_before", resp_err, 1'b0);
        @(negedge clk);
        id_ready = 1'b0;
        gnt_on   = 1'b1;
        repeat (6) @(negedge clk);
        gnt_on = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        spur_req = 1'b1;
        @(negedge clk);
        #3;
        check("err_set",  resp_err, 1'b1);
        check("err_idv",  id_valid, 1'b1);
        repeat (3) @(negedge clk);
        #3;
        check("err_sticky", resp_err, 1'b1);
        @(negedge clk);
        id_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        check("err_drained", id_valid, 1'b0);

        // Asynchronous reset in the middle of streaming
        gnt_on = 1'b1;
        repeat (5) @(negedge clk);
        pulse_reset();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_ifetch_prefetch
`default_nettype wire
